// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
`timescale 1ns/1ps

module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic [3:0]       aluop_EX,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic             op_rem_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic             valid_op;
  logic             is_uns;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             ovf;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             take;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic             unused_funct3;

  assign unused_funct3 = ^funct3[2:1];

  assign valid_op = (aluop_EX[3:1] == 3'b111);
  assign is_uns   = funct3[0];
  assign a_neg    = !is_uns && a[WIDTH-1];
  assign b_neg    = !is_uns && b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = (b == '0);
  assign ovf      = !is_uns && (a == MIN_NEG) && (b == '1);

  // One restoring step: the dividend register shifts its MSB into the
  // partial remainder and receives the new quotient bit at its LSB.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};
  assign take      = !rem_diff[WIDTH];
  assign rem_nxt   = take ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_nxt   = {dvd_q[WIDTH-2:0], take};
  assign q_final   = q_neg_q ? -quo_nxt : quo_nxt;
  assign r_final   = r_neg_q ? -rem_nxt : rem_nxt;

  assign busy = rst_n &&
                ((state == CALC) || ((state == IDLE) && start && !kill && valid_op));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      op_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
    end else if (kill) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && valid_op) begin
            op_rem_q <= aluop_EX[0];
            q_neg_q  <= a_neg ^ b_neg;
            r_neg_q  <= a_neg;
            dvd_q    <= a_mag;
            dvs_q    <= b_mag;
            rem_q    <= '0;
            cnt_q    <= '0;
            if (div_zero) begin
              result <= aluop_EX[0] ? a : '1;
              done   <= 1'b1;
              state  <= DONE;
            end else if (ovf) begin
              result <= aluop_EX[0] ? '0 : MIN_NEG;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          dvd_q <= quo_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            result <= op_rem_q ? r_final : q_final;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
`timescale 1ns/1ps

module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [3:0]  aluop_EX;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_fail;

  localparam logic [3:0] OP_Q = 4'b1110;
  localparam logic [3:0] OP_R = 4'b1111;
  localparam logic [2:0] F_S  = 3'b100;
  localparam logic [2:0] F_U  = 3'b101;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .kill     (kill),
    .aluop_EX (aluop_EX),
    .funct3   (funct3),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [2:0] f3,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp, input int exp_lat);
    int cycles;
    int busy_cnt;
    @(posedge clk); #1;
    start = 1'b1; aluop_EX = op; funct3 = f3; a = av; b = bv;
    #1;
    busy_cnt = busy ? 1 : 0;
    cycles = 0;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_0003;
    cycles = 1;
    while (!done && cycles < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, " latency"}, 32'(cycles), 32'(exp_lat));
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, " result"}, result, exp);
    check({tag, " busy in done"}, {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, " done one cycle"}, {31'b0, done}, 32'd0);
    check({tag, " result held"}, result, exp);
  endtask

  initial begin
    int seen;
    logic [31:0] prior;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0;
    aluop_EX = 4'b0000; funct3 = 3'b000; a = '0; b = '0;
    #12;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op("div 100/7",        OP_Q, F_S, 32'd100,      32'd7,        32'd14,       33);
    do_op("rem -100/7",       OP_R, F_S, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33);
    do_op("div -100/7",       OP_Q, F_S, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33);
    do_op("divu ffffffff/2",  OP_Q, F_U, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 33);
    do_op("remu ffffffff/2",  OP_R, F_U, 32'hFFFFFFFF, 32'd2,        32'd1,        33);
    do_op("div -1/2",         OP_Q, F_S, 32'hFFFFFFFF, 32'd2,        32'd0,        33);
    do_op("div 7/-3",         OP_Q, F_S, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFE, 33);
    do_op("rem 7/-3",         OP_R, F_S, 32'd7,        32'hFFFFFFFD, 32'd1,        33);
    do_op("divu min/-1",      OP_Q, F_U, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33);
    do_op("div 5/0",          OP_Q, F_S, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    do_op("remu 5/0",         OP_R, F_U, 32'd5,        32'd0,        32'd5,        1);
    do_op("divu 5/0",         OP_Q, F_U, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    do_op("div ovf",          OP_Q, F_S, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    do_op("rem ovf",          OP_R, F_S, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Kill mid-calculation, then an immediate restart.
    prior = result;
    @(posedge clk); #1;
    start = 1'b1; aluop_EX = OP_Q; funct3 = F_S; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("kill busy before", {31'b0, busy}, 32'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill busy after", {31'b0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    check("kill no done", 32'(seen), 32'd0);
    check("kill result kept", result, prior);
    do_op("div after kill", OP_Q, F_S, 32'd100, 32'd7, 32'd14, 33);

    // Reset asserted mid-calculation clears outputs asynchronously.
    @(posedge clk); #1;
    start = 1'b1; aluop_EX = OP_Q; funct3 = F_S; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", {31'b0, busy}, 32'd0);
    check("async rst done", {31'b0, done}, 32'd0);
    check("async rst result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Start with kill in IDLE, and a start with a non-divide op.
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b1; aluop_EX = OP_Q; funct3 = F_S; a = 32'd9; b = 32'd3;
    #1;
    check("start+kill busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("start+kill busy next", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b1; aluop_EX = 4'b0000;
    #1;
    check("bad op busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen++;
      @(posedge clk); #1;
    end
    check("no activity", 32'(seen), 32'd0);
    check("result still clear", result, 32'd0);

    do_op("final div 9/3", OP_Q, F_S, 32'd9, 32'd3, 32'd3, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
